poly_mod_diff_seq: RTL and testbench

Sequencer for whole-polynomial coefficient-wise modular subtraction, r[i] = (a[i] − b[i]) mod Q for i = 0..N−1. It streams operand reads from two coefficient RAMs, runs one registered modular-correction stage (the poly_mod_diff datapath), and writes results to a third RAM. It sits between the Kyber top-level control FSM and the polynomial buffers. It has a start/busy/done handshake and a fixed, stall-free schedule.

---
 rtl/poly_mod_diff_seq.sv | 139 +++++++++++++
 tb/tb_poly_mod_diff_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_mod_diff_seq.sv
// Streaming sequencer for r[i] = (a[i] - b[i]) mod Q over a whole polynomial.
// Define POLY_SEQ_ADD_EN to add the i_op_add port and a per-job modular add path.
module poly_mod_diff_seq #(
   parameter int WIDTH = 12,
   parameter int Q     = 3329,
   parameter int N     = 256,
   parameter int AW    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
`ifdef POLY_SEQ_ADD_EN
   input  logic             i_op_add,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic             o_rd_en,
   output logic [AW-1:0]    o_rd_addr,
   input  logic [WIDTH-1:0] i_a_rdata,
   input  logic [WIDTH-1:0] i_b_rdata,
   output logic             o_wr_en,
   output logic [AW-1:0]    o_wr_addr,
   output logic [WIDTH-1:0] o_wr_data
);

   localparam logic [WIDTH:0]  Q_EXT = (WIDTH+1)'(Q);
   localparam logic [AW-1:0]   LAST  = AW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_rd_addr;
   logic [AW-1:0]    w_rd_addr_nxt;
   logic             r_v1;
   logic             r_v2;
   logic [AW-1:0]    r_v1_addr;
   logic [AW-1:0]    r_wr_addr;
   logic [WIDTH-1:0] r_wr_data;
   logic             w_rd_en;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_result;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_rd_addr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_addr <= w_rd_addr_nxt;
      end
   end

   // DRAIN exits once stage 1 is empty, so stage 2 empties on that same edge.
   always_comb begin
      w_state_nxt   = r_state;
      w_rd_addr_nxt = r_rd_addr;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt   = RUN;
               w_rd_addr_nxt = '0;
            end
         end
         RUN: begin
            if (r_rd_addr == LAST) begin
               w_state_nxt = DRAIN;
            end else begin
               w_rd_addr_nxt = r_rd_addr + 1'b1;
            end
         end
         DRAIN: begin
            if (!r_v1) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_rd_en   = (r_state == RUN);
   assign o_rd_en   = w_rd_en;
   assign o_rd_addr = r_rd_addr;
   assign o_busy    = (r_state == RUN) || (r_state == DRAIN);
   assign o_done    = (r_state == DONE);

   // Single correction step only; out-of-range operands are not reduced further.
   assign w_diff = {1'b0, i_a_rdata} - {1'b0, i_b_rdata};
   assign w_sub  = w_diff[WIDTH] ? WIDTH'(w_diff + Q_EXT) : w_diff[WIDTH-1:0];

`ifdef POLY_SEQ_ADD_EN
   logic             r_op_add;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_add;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op_add <= 1'b0;
      end else if ((r_state == IDLE) && i_start) begin
         r_op_add <= i_op_add;
      end
   end

   assign w_sum    = {1'b0, i_a_rdata} + {1'b0, i_b_rdata};
   assign w_add    = (w_sum >= Q_EXT) ? WIDTH'(w_sum - Q_EXT) : w_sum[WIDTH-1:0];
   assign w_result = r_op_add ? w_add : w_sub;
`else
   assign w_result = w_sub;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_v1_addr <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_v1      <= w_rd_en;
         r_v2      <= r_v1;
         r_v1_addr <= r_rd_addr;
         if (r_v1) begin
            r_wr_addr <= r_v1_addr;
            r_wr_data <= w_result;
         end
      end
   end

   assign o_wr_en   = r_v2;
   assign o_wr_addr = r_wr_addr;
   assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_poly_mod_diff_seq.sv
// Directed scoreboard bench for poly_mod_diff_seq with a registered-read RAM model.
// Builds with or without POLY_SEQ_ADD_EN; the add-mode job runs only when it is defined.
module tb_poly_mod_diff_seq;

   localparam int WIDTH = 12;
   localparam int Q     = 3329;
   localparam int N     = 256;
   localparam int AW    = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic             rdEn;
   logic [AW-1:0]    rdAddr;
   logic [WIDTH-1:0] aData = '0;
   logic [WIDTH-1:0] bData = '0;
   logic             wrEn;
   logic [AW-1:0]    wrAddr;
   logic [WIDTH-1:0] wrData;
`ifdef POLY_SEQ_ADD_EN
   logic             opAdd;
`endif

   int memA [N];
   int memB [N];
   int expQ [$];
   int checks   = 0;
   int failures = 0;
   bit addMode  = 1'b0;

   always #5 clk = ~clk;

   poly_mod_diff_seq #(.WIDTH(WIDTH), .Q(Q), .N(N), .AW(AW)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
`ifdef POLY_SEQ_ADD_EN
      .i_op_add  (opAdd),
`endif
      .o_busy    (busy),
      .o_done    (done),
      .o_rd_en   (rdEn),
      .o_rd_addr (rdAddr),
      .i_a_rdata (aData),
      .i_b_rdata (bData),
      .o_wr_en   (wrEn),
      .o_wr_addr (wrAddr),
      .o_wr_data (wrData)
   );

   // Operand RAMs: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (rdEn) begin
         aData <= WIDTH'(memA[rdAddr]);
         bData <= WIDTH'(memB[rdAddr]);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int modelResult(input int a, input int b, input bit add);
      if (add) return (a + b) % Q;
      return (a + Q - b) % Q;
   endfunction

   task automatic pushJob();
      for (int i = 0; i < N; i++) begin
         expQ.push_back((i << 16) | modelResult(memA[i], memB[i], addMode));
      end
   endtask

   task automatic loadRamp();
      for (int i = 0; i < N; i++) begin
         memA[i] = i;
         memB[i] = 0;
      end
      pushJob();
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_ctrl"}, 32'({busy, done, rdEn, wrEn}), 32'd0);
      checkOutput({tag, "_rd_addr"}, 32'(rdAddr), 32'd0);
      checkOutput({tag, "_wr_addr"}, 32'(wrAddr), 32'd0);
      checkOutput({tag, "_wr_data"}, 32'(wrData), 32'd0);
   endtask

   // Runs one job; n counts cycles after the accept edge E0 (n = i means after Ei).
   task automatic applyStimulus(input bit holdStart, input int resetAt);
      int  n       = 0;
      int  firstWr = -1;
      int  doneAt  = -1;
      int  wrCount = 0;
      int  stray   = 0;
      bit  aborted = 1'b0;
      logic [31:0] obs;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      while (doneAt < 0 && n < 400 && !aborted) begin
         @(negedge clk);
         if (!holdStart) start = 1'b0;
         if (n == 0) begin
            checkOutput("accept_busy_rd", 32'({busy, rdEn, done}), 32'b110);
            checkOutput("accept_rd_addr", 32'(rdAddr), 32'd0);
         end
         if (wrEn) begin
            wrCount++;
            if (firstWr < 0) firstWr = n;
            obs = {8'd0, wrAddr, 4'd0, wrData};
            if (expQ.size() == 0) checkOutput("unexpected_write", obs, 32'hFFFF_FFFF);
            else checkOutput("write_addr_data", obs, 32'(expQ.pop_front()));
         end
         if (done) begin
            doneAt = n;
            checkOutput("busy_in_done", 32'(busy), 32'd0);
         end
         if (n == resetAt) begin
            rst     = 1'b1;
            aborted = 1'b1;
         end
         n++;
      end
      if (aborted) begin
         @(negedge clk);
         checkIdleOutputs("after_reset");
         rst = 1'b0;
         start = 1'b0;
         expQ.delete();
         repeat (20) begin
            @(negedge clk);
            if (wrEn || done || busy) stray++;
         end
         checkOutput("no_activity_after_reset", 32'(stray), 32'd0);
      end else begin
         checkOutput("done_seen", 32'(doneAt >= 0), 32'd1);
         checkOutput("first_write_cycle", 32'(firstWr), 32'd2);
         checkOutput("done_cycle", 32'(doneAt), 32'(N + 2));
         checkOutput("write_count", 32'(wrCount), 32'(N));
         checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
         expQ.delete();
         @(negedge clk);
         start = 1'b0;
         checkOutput("idle_after_done", 32'(busy), 32'd0);
         @(negedge clk);
         checkOutput("no_accept_from_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
`ifdef POLY_SEQ_ADD_EN
      opAdd = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
      rst = 1'b0;

      $display("[TB] ramp job");
      loadRamp();
      applyStimulus(1'b0, -1);

      $display("[TB] wrap job");
      for (int i = 0; i < N; i++) begin
         memA[i] = 0;
         memB[i] = 1;
      end
      memA[10] = 5;    memB[10] = 3328;
      memA[20] = 1234; memB[20] = 1234;
      pushJob();
      applyStimulus(1'b0, -1);

      $display("[TB] random jobs");
      for (int j = 0; j < 20; j++) begin
         for (int i = 0; i < N; i++) begin
            memA[i] = int'($urandom_range(0, Q - 1));
            memB[i] = int'($urandom_range(0, Q - 1));
         end
         pushJob();
         applyStimulus(1'b0, -1);
      end

      $display("[TB] start held through job and done cycle");
      loadRamp();
      applyStimulus(1'b1, -1);

      $display("[TB] reset mid-job then full job");
      loadRamp();
      applyStimulus(1'b0, 100);
      loadRamp();
      applyStimulus(1'b0, -1);

`ifdef POLY_SEQ_ADD_EN
      $display("[TB] add mode job");
      addMode = 1'b1;
      opAdd   = 1'b1;
      for (int i = 0; i < N; i++) begin
         memA[i] = i;
         memB[i] = i;
      end
      memA[0] = 3328; memB[0] = 1;
      memA[1] = 3000; memB[1] = 328;
      memA[2] = 1;    memB[2] = 2;
      pushJob();
      applyStimulus(1'b0, -1);
      opAdd   = 1'b0;
      addMode = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
